// File: rtl/grid_nav_ctrl.sv
// grid_nav_ctrl: edge-triggered grid mover with wall map and saturating move counter.
// Define GRID_WRAP_EN to wrap off-edge moves instead of rejecting them.
module grid_nav_ctrl #(
    parameter int X_W        = 3,
    parameter int Y_W        = 2,
    parameter int GRID_MAX_X = 7,
    parameter int GRID_MAX_Y = 3,
    parameter int START_X    = 7,
    parameter int START_Y    = 3,
    parameter logic [2**(X_W+Y_W)-1:0] WALL_MAP = '0,
    parameter int CNT_W      = 8
) (
    input  logic                 clk_50MHz_i,
    input  logic                 rst_async_la_i,
    input  logic [3:0]           key_in,
    input  logic                 enable_move,
    output logic [Y_W+X_W-1:0]   address,
    output logic [X_W-1:0]       posx,
    output logic [Y_W-1:0]       posy,
    output logic                 move_o,
    output logic                 bump_o,
    output logic                 busy_o,
    output logic [CNT_W-1:0]     move_count
);

    typedef enum logic [2:0] {IDLE, EVAL, COMMIT, REJECT, HOLD} state_t;

    localparam logic [X_W:0] MAX_X = GRID_MAX_X[X_W:0];
    localparam logic [Y_W:0] MAX_Y = GRID_MAX_Y[Y_W:0];
    localparam logic [X_W:0] ONE_X = (X_W+1)'(1);
    localparam logic [Y_W:0] ONE_Y = (Y_W+1)'(1);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    state_t             state_q, state_d;
    logic [3:0]         dir_q, dir_d;
    logic [X_W-1:0]     posx_q, posx_d;
    logic [Y_W-1:0]     posy_q, posy_d;
    logic               move_q, move_d;
    logic               bump_q, bump_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sync1_q, sync1_d;
    logic               en_s_q, en_s_d;
    logic               en_d_q, en_d_d;

    logic               rise;
    logic               dir_ok;
    logic               ok;
    logic [X_W:0]       tx;
    logic [Y_W:0]       ty;

    assign rise = en_s_q & ~en_d_q;

    // Target is one bit wider than the coordinate so under/overflow is visible
    always_comb begin
        tx     = {1'b0, posx_q};
        ty     = {1'b0, posy_q};
        dir_ok = 1'b1;
        case (dir_q)
            4'd2:    ty = ty - ONE_Y;
            4'd8:    ty = ty + ONE_Y;
            4'd4:    tx = tx - ONE_X;
            4'd6:    tx = tx + ONE_X;
            default: dir_ok = 1'b0;
        endcase
`ifdef GRID_WRAP_EN
        if (tx > MAX_X) tx = (dir_q == 4'd4) ? MAX_X : '0;
        if (ty > MAX_Y) ty = (dir_q == 4'd2) ? MAX_Y : '0;
`endif
        ok = dir_ok && (tx <= MAX_X) && (ty <= MAX_Y)
             && !WALL_MAP[{ty[Y_W-1:0], tx[X_W-1:0]}];
    end

    always_comb begin
        sync1_d = enable_move;
        en_s_d  = sync1_q;
        en_d_d  = en_s_q;
        state_d = state_q;
        dir_d   = dir_q;
        posx_d  = posx_q;
        posy_d  = posy_q;
        move_d  = 1'b0;
        bump_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    dir_d   = key_in;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (ok) begin
                    posx_d  = tx[X_W-1:0];
                    posy_d  = ty[Y_W-1:0];
                    move_d  = 1'b1;
                    if (cnt_q != '1) cnt_d = cnt_q + ONE_C;
                    state_d = COMMIT;
                end else begin
                    bump_d  = 1'b1;
                    state_d = REJECT;
                end
            end
            COMMIT:  state_d = HOLD;
            REJECT:  state_d = HOLD;
            HOLD:    if (!en_s_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            state_q <= IDLE;
            dir_q   <= '0;
            posx_q  <= START_X[X_W-1:0];
            posy_q  <= START_Y[Y_W-1:0];
            move_q  <= 1'b0;
            bump_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            sync1_q <= 1'b0;
            en_s_q  <= 1'b0;
            en_d_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            posx_q  <= posx_d;
            posy_q  <= posy_d;
            move_q  <= move_d;
            bump_q  <= bump_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            sync1_q <= sync1_d;
            en_s_q  <= en_s_d;
            en_d_q  <= en_d_d;
        end
    end

    assign posx       = posx_q;
    assign posy       = posy_q;
    assign address    = {posy_q, posx_q};
    assign move_o     = move_q;
    assign bump_o     = bump_q;
    assign busy_o     = busy_q;
    assign move_count = cnt_q;

endmodule
